// File: rtl/pipeline_swap_sequencer_pkg.sv
// rtl/pipeline_swap_sequencer_pkg.sv - swap FSM state encodings and fade length bounds
package pipeline_swap_sequencer_pkg;

   typedef enum logic [1:0] {
      SWAP_STATE_IDLE         = 2'd0,
      SWAP_STATE_WAIT_STANDBY = 2'd1,
      SWAP_STATE_FADING       = 2'd2,
      SWAP_STATE_COMMIT       = 2'd3
   } swap_state_e;

   localparam int FADE_LEN_LOG2_MIN = 1;
   localparam int FADE_LEN_LOG2_MAX = 12;

   function automatic logic legal_fade_len(input int l);
      return (l >= FADE_LEN_LOG2_MIN) && (l <= FADE_LEN_LOG2_MAX);
   endfunction

endpackage

// File: rtl/pipeline_swap_sequencer_if.sv
// rtl/pipeline_swap_sequencer_if.sv - control and sample bus between pipelines, sequencer and mixer
interface pipeline_swap_sequencer_if #(
   parameter int DATA_WIDTH = 16
);
   logic                         swap_req;
   logic                         standby_syncing;
   logic                         standby_resetting;
   logic                         sample_tick;
   logic signed [DATA_WIDTH-1:0] sample_a;
   logic signed [DATA_WIDTH-1:0] sample_b;
   logic signed [DATA_WIDTH-1:0] out_sample;
   logic                         out_valid;
   logic                         current_pipeline;
   logic                         swapping;
   logic                         swap_done;

   modport master (
      output swap_req, standby_syncing, standby_resetting, sample_tick, sample_a, sample_b,
      input  out_sample, out_valid, current_pipeline, swapping, swap_done
   );

   modport slave (
      input  swap_req, standby_syncing, standby_resetting, sample_tick, sample_a, sample_b,
      output out_sample, out_valid, current_pipeline, swapping, swap_done
   );
endinterface

// File: rtl/pipeline_swap_sequencer_crossfade_mac.sv
// rtl/pipeline_swap_sequencer_crossfade_mac.sv - 2-stage weighted sum (active*(2^L-w) + standby*w) >>> L
module pipeline_swap_sequencer_crossfade_mac #(
   parameter int DATA_WIDTH    = 16,
   parameter int FADE_LEN_LOG2 = 8
) (
   input  logic                         i_clk,
   input  logic                         i_reset,
   input  logic signed [DATA_WIDTH-1:0] i_active,
   input  logic signed [DATA_WIDTH-1:0] i_standby,
   input  logic [FADE_LEN_LOG2:0]       i_weight,
   input  logic                         i_valid,
   output logic signed [DATA_WIDTH-1:0] o_sample,
   output logic                         o_valid
);
   localparam int L  = FADE_LEN_LOG2;
   localparam int PW = DATA_WIDTH + L + 2;
   localparam logic [L:0] FULL_WEIGHT = {1'b1, {L{1'b0}}};

   logic [L:0]                   w_cweight;
   logic signed [PW-1:0]         w_active_ext;
   logic signed [PW-1:0]         w_standby_ext;
   logic signed [PW-1:0]         w_cweight_ext;
   logic signed [PW-1:0]         w_weight_ext;
   logic signed [PW-1:0]         w_prod_a;
   logic signed [PW-1:0]         w_prod_s;
   logic signed [PW:0]           w_sum;
   logic signed [DATA_WIDTH-1:0] w_mix;

   logic signed [PW-1:0]         r_prod_a;
   logic signed [PW-1:0]         r_prod_s;
   logic                         r_valid1;
   logic signed [DATA_WIDTH-1:0] r_sample;
   logic                         r_valid2;

   // Weights are non-negative, so they are zero-extended before the signed multiply.
   assign w_cweight     = FULL_WEIGHT - i_weight;
   assign w_active_ext  = {{(L+2){i_active[DATA_WIDTH-1]}}, i_active};
   assign w_standby_ext = {{(L+2){i_standby[DATA_WIDTH-1]}}, i_standby};
   assign w_cweight_ext = {{(DATA_WIDTH+1){1'b0}}, w_cweight};
   assign w_weight_ext  = {{(DATA_WIDTH+1){1'b0}}, i_weight};
   assign w_prod_a      = w_active_ext * w_cweight_ext;
   assign w_prod_s      = w_standby_ext * w_weight_ext;

   // Convex combination: the floored quotient always fits back into DATA_WIDTH.
   assign w_sum = {r_prod_a[PW-1], r_prod_a} + {r_prod_s[PW-1], r_prod_s};
   assign w_mix = DATA_WIDTH'(w_sum >>> L);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_prod_a <= '0;
         r_prod_s <= '0;
         r_valid1 <= 1'b0;
         r_sample <= '0;
         r_valid2 <= 1'b0;
      end else begin
         r_prod_a <= w_prod_a;
         r_prod_s <= w_prod_s;
         r_valid1 <= i_valid;
         r_sample <= w_mix;
         r_valid2 <= r_valid1;
      end
   end

   assign o_sample = r_sample;
   assign o_valid  = r_valid2;

endmodule

// File: rtl/pipeline_swap_sequencer.sv
// rtl/pipeline_swap_sequencer.sv - active/standby pipeline handover with a linear sample crossfade
module pipeline_swap_sequencer
   import pipeline_swap_sequencer_pkg::*;
#(
   parameter int DATA_WIDTH    = 16,
   parameter int FADE_LEN_LOG2 = 8
) (
   input  logic                       i_clk,
   input  logic                       i_reset,
   pipeline_swap_sequencer_if.slave   bus
);
   localparam int L = FADE_LEN_LOG2;

   if (!legal_fade_len(FADE_LEN_LOG2)) begin : g_bad_fade_len
      $error("FADE_LEN_LOG2 out of legal range");
   end

   swap_state_e                  r_state;
   logic [L-1:0]                 r_ctr;
   logic                         r_current;
   logic                         r_swap_done;

   logic [L:0]                   w_weight;
   logic signed [DATA_WIDTH-1:0] w_active;
   logic signed [DATA_WIDTH-1:0] w_standby;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state     <= SWAP_STATE_IDLE;
         r_ctr       <= '0;
         r_current   <= 1'b0;
         r_swap_done <= 1'b0;
      end else begin
         r_swap_done <= 1'b0;
         case (r_state)
            SWAP_STATE_IDLE: begin
               if (bus.swap_req) r_state <= SWAP_STATE_WAIT_STANDBY;
            end
            SWAP_STATE_WAIT_STANDBY: begin
               if (!bus.standby_syncing && !bus.standby_resetting) begin
                  r_ctr   <= '0;
                  r_state <= SWAP_STATE_FADING;
               end
            end
            SWAP_STATE_FADING: begin
               if (bus.sample_tick) begin
                  r_ctr <= r_ctr + 1'b1;
                  if (r_ctr == {L{1'b1}}) r_state <= SWAP_STATE_COMMIT;
               end
            end
            SWAP_STATE_COMMIT: begin
               r_current   <= ~r_current;
               r_swap_done <= 1'b1;
               r_state     <= SWAP_STATE_IDLE;
            end
            default: r_state <= SWAP_STATE_IDLE;
         endcase
      end
   end

   // During COMMIT the old selection is still live, so full weight yields pure standby.
   always_comb begin
      w_weight = '0;
      case (r_state)
         SWAP_STATE_FADING: w_weight = {1'b0, r_ctr};
         SWAP_STATE_COMMIT: w_weight = {1'b1, {L{1'b0}}};
         default:           w_weight = '0;
      endcase
   end

   assign w_active  = r_current ? bus.sample_b : bus.sample_a;
   assign w_standby = r_current ? bus.sample_a : bus.sample_b;

   pipeline_swap_sequencer_crossfade_mac #(
      .DATA_WIDTH    (DATA_WIDTH),
      .FADE_LEN_LOG2 (FADE_LEN_LOG2)
   ) u_mac (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_active  (w_active),
      .i_standby (w_standby),
      .i_weight  (w_weight),
      .i_valid   (bus.sample_tick),
      .o_sample  (bus.out_sample),
      .o_valid   (bus.out_valid)
   );

   assign bus.current_pipeline = r_current;
   assign bus.swapping         = (r_state != SWAP_STATE_IDLE);
   assign bus.swap_done        = r_swap_done;

endmodule

// File: tb/tb_pipeline_swap_sequencer.sv
// tb/tb_pipeline_swap_sequencer.sv - directed table-driven bench for pipeline_swap_sequencer (L=2)
module tb_pipeline_swap_sequencer;
   localparam int DW = 16;
   localparam int L  = 2;

   logic clk;
   logic reset;
   int   cyc;
   int   tests;
   int   fails;
   int   done_cnt;
   int   out_q[$];
   int   out_cyc[$];

   pipeline_swap_sequencer_if #(.DATA_WIDTH(DW)) bus ();

   pipeline_swap_sequencer #(
      .DATA_WIDTH    (DW),
      .FADE_LEN_LOG2 (L)
   ) dut (
      .i_clk   (clk),
      .i_reset (reset),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.out_valid) begin
         out_q.push_back(int'(bus.out_sample));
         out_cyc.push_back(cyc);
      end
      if (bus.swap_done) done_cnt++;
   end

   typedef struct {
      int a;
      int b;
      int exp0;
      int exp1;
   } pass_vec_t;

   pass_vec_t pass_tbl[6];
   int        fade_up[5];
   int        fade_dn[5];

   task automatic check(input string name, input int got, input int exp);
      tests++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) cycle();
   endtask

   task automatic clear_obs();
      out_q.delete();
      out_cyc.delete();
      done_cnt = 0;
   endtask

   task automatic send_tick(input int a, input int b);
      bus.sample_a    = DW'(a);
      bus.sample_b    = DW'(b);
      bus.sample_tick = 1'b1;
      cycle();
      bus.sample_tick = 1'b0;
   endtask

   task automatic pulse_swap();
      bus.swap_req = 1'b1;
      cycle();
      bus.swap_req = 1'b0;
   endtask

   function automatic int q_at(input int i);
      return (i < out_q.size()) ? out_q[i] : 32'h7fffffff;
   endfunction

   task automatic do_reset();
      reset = 1'b1;
      idle(2);
      reset = 1'b0;
   endtask

   task automatic run_pass_table(input logic cur);
      int c;
      for (int i = 0; i < 6; i++) begin
         clear_obs();
         c = cyc;
         send_tick(pass_tbl[i].a, pass_tbl[i].b);
         idle(3);
         check($sformatf("pass%0d_cur%0d_count", i, cur), out_q.size(), 1);
         check($sformatf("pass%0d_cur%0d_value", i, cur), q_at(0),
               cur ? pass_tbl[i].exp1 : pass_tbl[i].exp0);
         check($sformatf("pass%0d_cur%0d_latency", i, cur),
               (out_cyc.size() > 0) ? out_cyc[0] - c : -1, 2);
         check($sformatf("pass%0d_cur%0d_current", i, cur), int'(bus.current_pipeline), int'(cur));
      end
   endtask

   task automatic spaced_fade(input string name, input int exp[5]);
      for (int k = 0; k < 5; k++) begin
         send_tick(1000, -1000);
         idle(3);
      end
      check({name, "_count"}, out_q.size(), 5);
      for (int k = 0; k < 5; k++)
         check($sformatf("%s_out%0d", name, k), q_at(k), exp[k]);
   endtask

   initial begin
      cyc   = 0;
      tests = 0;
      fails = 0;
      reset = 1'b1;
      bus.swap_req          = 1'b0;
      bus.standby_syncing   = 1'b0;
      bus.standby_resetting = 1'b0;
      bus.sample_tick       = 1'b0;
      bus.sample_a          = '0;
      bus.sample_b          = '0;

      pass_tbl[0] = '{1000, -1000, 1000, -1000};
      pass_tbl[1] = '{32767, -32768, 32767, -32768};
      pass_tbl[2] = '{-32768, 5, -32768, 5};
      pass_tbl[3] = '{0, 123, 0, 123};
      pass_tbl[4] = '{-1, 1, -1, 1};
      pass_tbl[5] = '{-7, 32767, -7, 32767};
      fade_up = '{1000, 500, 0, -500, -1000};
      fade_dn = '{-1000, -500, 0, 500, 1000};

      idle(3);
      check("rst_out_sample", int'(bus.out_sample), 0);
      check("rst_out_valid", int'(bus.out_valid), 0);
      check("rst_current", int'(bus.current_pipeline), 0);
      check("rst_swapping", int'(bus.swapping), 0);
      check("rst_swap_done", int'(bus.swap_done), 0);
      reset = 1'b0;
      idle(2);

      run_pass_table(1'b0);

      // Full fade with ticks every 4 cycles
      clear_obs();
      pulse_swap();
      check("fade_swapping_rise", int'(bus.swapping), 1);
      idle(1);
      spaced_fade("full_fade", fade_up);
      check("full_fade_done_cnt", done_cnt, 1);
      check("full_fade_current", int'(bus.current_pipeline), 1);
      check("full_fade_swapping_fall", int'(bus.swapping), 0);

      run_pass_table(1'b1);

      // Sync gating, including a dropped request during WAIT_STANDBY
      do_reset();
      check("gate_reset_current", int'(bus.current_pipeline), 0);
      clear_obs();
      bus.standby_syncing = 1'b1;
      pulse_swap();
      for (int k = 0; k < 5; k++) begin
         if (k == 2) bus.swap_req = 1'b1;
         send_tick(1000, -1000);
         bus.swap_req = 1'b0;
         idle(3);
         check($sformatf("gate_swapping%0d", k), int'(bus.swapping), 1);
      end
      for (int k = 0; k < 5; k++) check($sformatf("gate_hold%0d", k), q_at(k), 1000);
      check("gate_no_done", done_cnt, 0);
      bus.standby_syncing = 1'b0;
      clear_obs();
      idle(1);
      spaced_fade("gate_fade", fade_up);
      check("gate_done_cnt", done_cnt, 1);
      check("gate_current", int'(bus.current_pipeline), 1);

      // Second request mid-fade is ignored
      clear_obs();
      pulse_swap();
      idle(1);
      for (int k = 0; k < 5; k++) begin
         if (k == 2) bus.swap_req = 1'b1;
         send_tick(1000, -1000);
         bus.swap_req = 1'b0;
         idle(3);
      end
      idle(6);
      check("midreq_count", out_q.size(), 5);
      for (int k = 0; k < 5; k++) check($sformatf("midreq_out%0d", k), q_at(k), fade_dn[k]);
      check("midreq_done_cnt", done_cnt, 1);
      check("midreq_current", int'(bus.current_pipeline), 0);
      check("midreq_swapping", int'(bus.swapping), 0);

      // Back-to-back ticks through the fade and commit
      clear_obs();
      pulse_swap();
      idle(1);
      bus.sample_a    = 16'sd1000;
      bus.sample_b    = -16'sd1000;
      bus.sample_tick = 1'b1;
      idle(5);
      bus.sample_tick = 1'b0;
      idle(4);
      check("b2b_count", out_q.size(), 5);
      for (int k = 0; k < 5; k++) check($sformatf("b2b_out%0d", k), q_at(k), fade_up[k]);
      for (int k = 1; k < 5; k++)
         check($sformatf("b2b_gap%0d", k),
               (k < out_cyc.size()) ? out_cyc[k] - out_cyc[k-1] : -1, 1);
      check("b2b_done_cnt", done_cnt, 1);
      check("b2b_current", int'(bus.current_pipeline), 1);

      // Reset mid-fade at ctr=2 with samples in flight
      pulse_swap();
      idle(1);
      bus.sample_tick = 1'b1;
      idle(2);
      bus.sample_tick = 1'b0;
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      check("midrst_current", int'(bus.current_pipeline), 0);
      check("midrst_out_valid", int'(bus.out_valid), 0);
      check("midrst_swapping", int'(bus.swapping), 0);
      clear_obs();
      idle(4);
      check("midrst_no_inflight", out_q.size(), 0);
      send_tick(1000, -1000);
      idle(3);
      check("midrst_pass_count", out_q.size(), 1);
      check("midrst_pass_value", q_at(0), 1000);
      check("midrst_no_done", done_cnt, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pipeline_swap_sequencer.md
# pipeline_swap_sequencer

Sequences the handover between the active and standby DSP pipelines. On a swap request it waits for the standby pipeline to finish register-file sync and reset, then crossfades the two pipeline outputs over 2^fade_len_log2 samples and commits the new `current_pipeline`. It sits between the two pipeline outputs and the output mixer. It replaces a hard, click-prone switch with a sample-accurate linear fade.

## Interface
- `data_width`, 16, sample width (signed two's complement)
- `fade_len_log2`, 8, log2 of fade length in samples; legal range 1..12
- `clk` in 1: the block's single clock.
- `reset` in 1: synchronous, active-high.
- `swap_req` in 1: single-cycle request from the control unit.
- `standby_syncing` in 1: standby pipeline regfile sync in progress.
- `standby_resetting` in 1: standby pipeline reset in progress.
- `sample_tick` in 1: one pulse per sample; both pipeline outputs are valid in this cycle.
- `sample_a` in data_width: pipeline 0 output.
- `sample_b` in data_width: pipeline 1 output.
- `out_sample` out data_width: faded or passthrough sample.
- `out_valid` out 1: qualifies `out_sample`.
- `current_pipeline` out 1: index of the active pipeline.
- `swapping` out 1: high whenever state ≠ IDLE.
- `swap_done` out 1: single-cycle pulse on commit.

## Operation
- Active sample = `current_pipeline ? sample_b : sample_a`; standby sample = the other.
- States (header constants) and transitions:
  - IDLE → WAIT_STANDBY on `swap_req`.
  - WAIT_STANDBY → FADING when `standby_syncing` = 0 and `standby_resetting` = 0; in that cycle `ctr` ← 0.
  - FADING: each `sample_tick` does `ctr` ← `ctr` + 1. The tick taken at `ctr` = 2^L−1 moves the state to COMMIT.
  - COMMIT: toggles `current_pipeline`, pulses `swap_done`, → IDLE (always one cycle).
- Weight `w` (L+1 bits, where L = `fade_len_log2`), captured with each tick:
  - IDLE / WAIT_STANDBY: `w` = 0.
  - FADING: `w` = `ctr`.
  - COMMIT: `w` = 2^L, i.e. pure standby. This is equivalent to the post-commit active pipeline.
- Mix: out = (active·(2^L − w) + standby·w) >>> L.
  - Signed products are data_width+L+2 bits; the sum adds one more bit.
  - The shift is arithmetic (floor). No saturation is needed, because the result is a convex combination.
- Ignored inputs and events:
  - `swap_req` while not IDLE is ignored; there is no queueing.
  - Requests arriving during WAIT_STANDBY are dropped.
  - Standby flags rising again during FADING are ignored; the fade continues.
- Ticks are processed in every state. Output never stalls.

## Timing
- Reset values:
  - state IDLE, `ctr` 0, `current_pipeline` 0.
  - `out_sample` 0, `out_valid` 0.
  - `swapping` 0, `swap_done` 0.
  - All pipeline registers are cleared.
- Latency: `out_valid` rises exactly 2 cycles after `sample_tick`.
  - Stage 1 registers the selected operands, `w`, and both products.
  - Stage 2 registers the sum and shift.
- Throughput: one tick per cycle is accepted.
- In-flight samples keep the operand selection and `w` captured at their tick cycle. The commit toggle does not affect them.
- `swap_req` and `sample_tick` in the same IDLE cycle: the tick uses `w` = 0. The state reaches WAIT_STANDBY on the next cycle.
- WAIT_STANDBY is entered with flags already clear: the next cycle is FADING.
- `swapping` rises the cycle after `swap_req` and falls the cycle after COMMIT.
- `current_pipeline` changes on the clock edge that leaves COMMIT, coincident with the `swap_done` pulse.
- Minimum swap time: 2 + 2^L ticks + 1 cycle.
- Reset mid-fade: return immediately to reset values.
  - `current_pipeline` returns to 0.
  - In-flight samples are discarded; no `out_valid` is produced.

## Structure
- Header (`engine.vh` style) holds:
  - state encodings SWAP_STATE_IDLE / WAIT_STANDBY / FADING / COMMIT;
  - the legal `fade_len_log2` bound.
- Sub-module `crossfade_mac`: the 2-stage pipelined weighted sum.
  - Inputs: active, standby, `w`, `valid`.
  - Outputs: `sample`, `valid`.
- The FSM, counter and `current_pipeline` register live in the top.

## Test plan
- Passthrough: L=2, `sample_a`=1000, `sample_b`=−1000, ticks every 4 cycles, no swap → `out_sample`=1000 each time, 2 cycles after each tick, `current_pipeline`=0.
- Full fade: same stimulus, `swap_req`, flags low → successive outputs 1000, 500, 0, −500, −1000. `swap_done` pulses once, `current_pipeline`=1, and subsequent outputs are −1000.
- Sync gating: `standby_syncing` held high for 20 cycles after `swap_req` → outputs stay 1000 and `swapping`=1 throughout; the fade starts only after the flag falls.
- Request during swap: second `swap_req` mid-FADING → exactly one `swap_done`, one toggle.
- Back-to-back ticks: `sample_tick` high every cycle during the fade → `out_valid` high every cycle, values as in the full-fade scenario, no lost samples.
- Reset mid-fade: assert `reset` at `ctr`=2 → next cycle `current_pipeline`=0, `out_valid`=0, `swapping`=0. A following tick yields the `sample_a` passthrough.
